// File: rtl/sram_pkg.sv
// Shared constants, FSM state type and logic-to-rail helper for the SRAM access path.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [2:0] {
        StIdle,
        StPrech,
        StWl,
        StSense,
        StRecov,
        StErr
    } state_t;

    // Map a registered control bit onto the supply rails.
    function automatic real l2r(input logic b);
        return b ? VDD : VSS;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that flags when the current phase has run out.
module sram_phase_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] len,
    output logic             zero
);

    logic [Width-1:0] cnt_d, cnt_q;

    // Load on phase entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_row_ctrl.sv
// Access sequencer in front of the SRAM row decoder: precharge, wordline, sense, recover.
module sram_row_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned PRE_CYC = 2,
    parameter int unsigned WL_CYC  = 3,
    parameter int unsigned SA_CYC  = 2,
    localparam int unsigned AW     = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    output real           row_sel [0:AW-1],
    output real           pre_en,
    output real           we_en,
    output real           sae,
    output logic          done,
    output logic          err
);

    localparam int unsigned MaxCyc =
        (PRE_CYC > WL_CYC) ? ((PRE_CYC > SA_CYC) ? PRE_CYC : SA_CYC)
                           : ((WL_CYC > SA_CYC) ? WL_CYC : SA_CYC);
    localparam int unsigned CW = $clog2(MaxCyc) + 1;

    localparam logic [CW-1:0] PreLen = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] WlLen  = CW'(WL_CYC - 1);
    localparam logic [CW-1:0] SaLen  = CW'(SA_CYC - 1);

    // Top row is reserved: its select code would wrap past the decoder range.
    localparam logic [AW-1:0] BadAddr = AW'(ROWS - 1);

    state_t        state_d, state_q;
    logic [AW-1:0] addr_d, addr_q;
    logic          we_d, we_q;
    logic          tmr_load;
    logic [CW-1:0] tmr_len;
    logic          tmr_zero;

    logic          wl_on;
    logic [AW-1:0] sel_code;
    logic          pre_bit, we_bit, sae_bit;

    sram_phase_timer #(
        .Width (CW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (tmr_len),
        .zero (tmr_zero)
    );

    // Next-state logic; each transition into a timed phase loads that phase's length.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        tmr_load = 1'b0;
        tmr_len  = '0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    we_d   = req_we;
                    if (req_addr == BadAddr) begin
                        state_d = StErr;
                    end else begin
                        state_d  = StPrech;
                        tmr_load = 1'b1;
                        tmr_len  = PreLen;
                    end
                end
            end
            StPrech: begin
                if (tmr_zero) begin
                    state_d  = StWl;
                    tmr_load = 1'b1;
                    tmr_len  = WlLen;
                end
            end
            StWl: begin
                if (tmr_zero) begin
                    if (we_q) begin
                        state_d = StRecov;
                    end else begin
                        state_d  = StSense;
                        tmr_load = 1'b1;
                        tmr_len  = SaLen;
                    end
                end
            end
            StSense: begin
                if (tmr_zero) begin
                    state_d = StRecov;
                end
            end
            StRecov: state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and captured request; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

    // Decode registered state into control bits, then map them onto the rails.
    always_comb begin
        wl_on    = (state_q == StWl) || (state_q == StSense);
        sel_code = wl_on ? (addr_q + 1'b1) : '0;
        pre_bit  = (state_q == StIdle) || (state_q == StPrech) || (state_q == StRecov);
        we_bit   = (state_q == StWl) && we_q;
        sae_bit  = (state_q == StSense);
        for (int i = 0; i < AW; i++) begin
            row_sel[i] = l2r(sel_code[i]);
        end
        pre_en = l2r(pre_bit);
        we_en  = l2r(we_bit);
        sae    = l2r(sae_bit);
    end

    assign done      = (state_q == StRecov);
    assign err       = (state_q == StErr);
    assign req_ready = (state_q == StIdle) && !rst;

endmodule

// File: tb/tb_sram_row_ctrl.sv
// Directed bench for sram_row_ctrl: phase-by-phase checks plus a done/err scoreboard.
module tb_sram_row_ctrl;

    localparam int AW = 4;
    localparam int P  = 2;
    localparam int W  = 3;
    localparam int S  = 2;

    typedef struct {
        logic is_err;
        int   cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    real           row_sel [0:AW-1];
    real           pre_en;
    real           we_en;
    real           sae;
    logic          done;
    logic          err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b1;
    exp_t sb_q[$];

    sram_row_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .row_sel   (row_sel),
        .pre_en    (pre_en),
        .we_en     (we_en),
        .sae       (sae),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Anything off-rail decodes to X so an exact compare rejects it.
    function automatic logic r2l(input real r);
        if (r == 1.5) return 1'b1;
        if (r == 0.0) return 1'b0;
        return 1'bx;
    endfunction

    function automatic logic [3:0] code_of();
        logic [3:0] c;
        for (int i = 0; i < AW; i++) c[i] = r2l(row_sel[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Invariants every cycle, and done/err matched against queued expectations.
    always @(negedge clk) begin
        logic [3:0] c;
        exp_t       e;
        if (mon_en) begin
            c = code_of();
            chk("inv_rail", {31'd0, (^{c, r2l(pre_en), r2l(we_en), r2l(sae)}) === 1'bx}, 32'd0);
            chk("inv_pre_wl", {31'd0, (r2l(pre_en) === 1'b1) && (c !== 4'd0)}, 32'd0);
            chk("inv_we_sae", {31'd0, (r2l(we_en) === 1'b1) && (r2l(sae) === 1'b1)}, 32'd0);
            if (done === 1'b1 || err === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {30'd0, done, err}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_kind", {31'd0, err}, {31'd0, e.is_err});
                    chk("sb_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Present a request and wait (bounded) for the transfer cycle.
    task automatic xfer(input logic we, input logic [3:0] addr, input logic push, output int t);
        int   n;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("xfer_ready", {31'd0, req_ready}, 32'd1);
        t = cyc;
        if (push) begin
            e.is_err = (addr == 4'd15);
            e.cyc    = t + ((addr == 4'd15) ? 1 : (we ? 1 + P + W : 1 + P + W + S));
            sb_q.push_back(e);
        end
    endtask

    // Walk one access cycle by cycle against the expected phase timeline.
    task automatic check_access(input logic we, input logic [3:0] addr, input int t,
                                input logic hold, input logic nwe, input logic [3:0] naddr);
        int         wl_end;
        int         sa_end;
        int         end_k;
        logic [3:0] ec;
        wl_end = P + W;
        sa_end = we ? wl_end : wl_end + S;
        end_k  = sa_end + 1;
        for (int k = 1; k <= end_k + 1; k++) begin
            tick();
            if (k == 1) begin
                if (hold) begin
                    req_we   = nwe;
                    req_addr = naddr;
                end else begin
                    req_valid = 1'b0;
                    req_we    = ~we;
                    req_addr  = ~addr;
                end
            end
            ec = (k >= P + 1 && k <= sa_end) ? addr + 4'd1 : 4'd0;
            chk("cyc_align", cyc, t + k);
            chk("sel_code", {28'd0, code_of()}, {28'd0, ec});
            chk("pre_en", {31'd0, r2l(pre_en)}, {31'd0, (k <= P) || (k >= end_k)});
            chk("we_en", {31'd0, r2l(we_en)}, {31'd0, we && k > P && k <= wl_end});
            chk("sae", {31'd0, r2l(sae)}, {31'd0, !we && k > wl_end && k <= sa_end});
            chk("done", {31'd0, done}, {31'd0, k == end_k});
            chk("err", {31'd0, err}, 32'd0);
            chk("ready", {31'd0, req_ready}, {31'd0, k == end_k + 1});
        end
    endtask

    initial begin
        int t;
        int t2;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd5;

        // Reset held with a request pending.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_pre", {31'd0, r2l(pre_en)}, 32'd1);
            chk("rst_sel", {28'd0, code_of()}, 32'd0);
            chk("rst_we", {31'd0, r2l(we_en)}, 32'd0);
            chk("rst_sae", {31'd0, r2l(sae)}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Read row 5.
        xfer(1'b0, 4'd5, 1'b1, t);
        check_access(1'b0, 4'd5, t, 1'b0, 1'b0, 4'd0);

        // Write row 0.
        xfer(1'b1, 4'd0, 1'b1, t);
        check_access(1'b1, 4'd0, t, 1'b0, 1'b0, 4'd0);

        // Out-of-range row.
        xfer(1'b0, 4'd15, 1'b1, t);
        tick();
        req_valid = 1'b0;
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_sel", {28'd0, code_of()}, 32'd0);
        chk("err_pre", {31'd0, r2l(pre_en)}, 32'd0);
        chk("err_done", {31'd0, done}, 32'd0);
        chk("err_ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("err_ready_back", {31'd0, req_ready}, 32'd1);
        chk("err_clear", {31'd0, err}, 32'd0);

        // Reset in cycle 4 of a read aborts it with no done.
        xfer(1'b0, 4'd9, 1'b0, t);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) req_valid = 1'b0;
        end
        chk("abort_wl_up", {28'd0, code_of()}, 32'd10);
        rst = 1'b1;
        tick();
        chk("abort_sel", {28'd0, code_of()}, 32'd0);
        chk("abort_pre", {31'd0, r2l(pre_en)}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_idle", {31'd0, req_ready}, 32'd1);

        // Fresh read after the abort.
        xfer(1'b0, 4'd2, 1'b1, t);
        check_access(1'b0, 4'd2, t, 1'b0, 1'b0, 4'd0);

        // Back-to-back: read 3 then write 14 with valid held.
        xfer(1'b0, 4'd3, 1'b1, t);
        check_access(1'b0, 4'd3, t, 1'b1, 1'b1, 4'd14);
        xfer(1'b1, 4'd14, 1'b1, t2);
        chk("b2b_gap", t2 - t, 32'd9);
        check_access(1'b1, 4'd14, t2, 1'b0, 1'b0, 4'd0);

        repeat (4) tick();
        chk("sb_drained", sb_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_row_ctrl.md
Name: sram_row_ctrl

Overview:
- Synchronous access sequencer that sits directly upstream of the SRAM row decoder.
- Accepts one read/write request at a time over a valid/ready handshake and runs the precharge → wordline → sense → recover timing.
- Drives the decoder's real-valued select bus and the array's real-valued precharge, write-enable and sense-amp enables.
- Rail levels: VDD = 1.5, VSS = 0.0. The decoder reads select code 0 as "no row" and code n as row n-1. This block therefore drives code addr+1 only while the wordline must be high, and code 0 at all other times.

Parameters:
- ROWS, 16: array rows; power of two, ≥4. Addressable rows are 0..ROWS-2.
- AW, $clog2(ROWS): address and select width; derived, not overridden.
- PRE_CYC, 2: precharge phase length in cycles, ≥1.
- WL_CYC, 3: wordline phase length in cycles, ≥1.
- SA_CYC, 2: sense phase length in cycles, ≥1; read only.

Ports:
- clk  input  1  clock. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  row address.
- row_sel  output  real [0:AW-1]  decoder select bits, each VDD or VSS.
- pre_en  output  real  bitline precharge enable, VDD or VSS.
- we_en  output  real  write driver enable, VDD or VSS.
- sae  output  real  sense-amp enable, VDD or VSS.
- done  output  1  one-cycle pulse when an access completes.
- err  output  1  one-cycle pulse when an out-of-range address is rejected.

Behaviour:
- Handshake and control state
  - Transfer occurs on a rising clk edge where req_valid && req_ready.
  - req_addr and req_we are captured at the transfer edge. Input changes afterwards are ignored.
  - req_ready = 1 only in IDLE; it is 0 while rst is high.
  - All control state is registered. Real outputs are a combinational logic→real map (1→VDD, 0→VSS) of registered bits, so they are glitch-free per cycle.
- Reset (rst high at an edge)
  - FSM goes to IDLE and all counters clear.
  - Outputs: row_sel all VSS, pre_en VDD, we_en VSS, sae VSS, done 0, err 0.
  - Reset mid-access aborts immediately: the wordline drops on the next edge and no done is issued.
- FSM states: IDLE, PRECH, WL, SENSE, RECOV, ERR.
  - IDLE: pre_en = VDD, row_sel = code 0.
    - On transfer with req_addr ≤ ROWS-2 → PRECH.
    - On transfer with req_addr = ROWS-1 → ERR.
  - PRECH: pre_en = VDD for PRE_CYC cycles → WL.
  - WL: pre_en = VSS, row_sel = addr+1, we_en = VDD if write, for WL_CYC cycles.
    - Then → SENSE if read, → RECOV if write.
  - SENSE: row_sel held at addr+1, sae = VDD, we_en = VSS, for SA_CYC cycles → RECOV.
  - RECOV: row_sel = code 0, sae/we_en = VSS, pre_en = VDD, done = 1, for 1 cycle → IDLE.
  - ERR: err = 1, no wordline, no enables, for 1 cycle → IDLE.
- Phase counter
  - Width $clog2(max(PRE_CYC,WL_CYC,SA_CYC))+1.
  - Loaded to phase length-1 on state entry, decremented each cycle; the state exits when it reaches 0.
- Latency, counted from the transfer edge as cycle 0
  - Read: done in cycle 1+PRE+WL+SA; defaults give cycle 8. req_ready returns in cycle 9.
  - Write: done in cycle 1+PRE+WL; defaults give cycle 6.
  - Error: err in cycle 1; ready in cycle 2.
- Invariants
  - At most one wordline code is nonzero at any time.
  - pre_en and a nonzero row_sel are never both VDD.
  - we_en and sae are never both VDD.
- Back-to-back requests: req_valid held high is accepted in the first IDLE cycle after RECOV/ERR. There is no bubble beyond that IDLE cycle.

Decomposition:
- Package sram_pkg
  - Constants: VDD = 1.5, VSS = 0.0, VTH = 0.8.
  - typedef enum state_t.
  - Function l2r(logic) → real, shared with the decoder and sense stages.
- Sub-module sram_phase_timer
  - Function: loadable down-counter with a zero flag.
  - Ports: clk, rst, load, len, zero.
- Top level: FSM, address capture, addr+1 encoding and real conversion.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=1 → req_ready=0, pre_en=1.5, row_sel all 0.0, done=err=0; after release, ready=1 next cycle.
- Read addr 5 with defaults → cycles 1–2 pre_en=1.5; cycles 3–7 row_sel encodes 6 (bit0=0.0, bit1=1.5, bit2=1.5, bit3=0.0); sae=1.5 in cycles 6–7; done=1 in cycle 8; ready=1 in cycle 9.
- Write addr 0 → row_sel encodes 1 and we_en=1.5 in cycles 3–5; sae stays 0.0 throughout; done=1 in cycle 6.
- Address 15 (ROWS=16) → err=1 in cycle 1, row_sel stays code 0, no done; ready=1 in cycle 2.
- Assert rst in cycle 4 of a read → row_sel code 0 and pre_en=1.5 on the next edge; no done; a fresh request completes normally.
- Back-to-back: read 3 then write 14 with req_valid held high → second transfer in the IDLE cycle after the first done; row_sel encodes 15 for the write; invariants checked every cycle.
